next_pc_unit: RTL and testbench
===============================

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: Clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: stall  input  1  hold PC this cycle.
REQ-005 SHALL have port: idPcPlus4  input  32  PC+4 of the instruction issuing the redirect.
REQ-006 SHALL have port: jumpEn  input  1  j/jal redirect request.
REQ-007 SHALL have port: jumpTarget28  input  28  instr[25:0] shifted left 2, zero-extended, from the jump-shift stage.
REQ-008 SHALL have port: branchEn  input  1  taken-branch redirect request.
REQ-009 SHALL have port: branchImm  input  16  raw branch immediate.
REQ-010 SHALL have port: jrEn  input  1  jr redirect request.
REQ-011 SHALL have port: jrTarget  input  32  register-sourced target.
REQ-012 SHALL have port: pcOut  output  32  registered current fetch PC.
REQ-013 SHALL have port: pcPlus4  output  32  combinational pcOut+4.
REQ-014 SHALL have port: flush  output  1  registered one-cycle IF/ID flush after redirect load.
REQ-015 SHALL have port: redirectPending  output  1  buffered redirect awaiting stall release.

Function
REQ-016 Jump target SHALL be {idPcPlus4[31:28], jumpTarget28}.
REQ-017 Branch target SHALL be idPcPlus4 + {{14{branchImm[15]}}, branchImm, 2'b00}, modulo 2^32.
REQ-018 jr target SHALL be {jrTarget[31:2], 2'b00}.
REQ-019 Redirect priority among simultaneous enables SHALL be jr > jump > branch.
REQ-020 "Redirect present" SHALL mean any of jrEn, jumpEn, branchEn high in that cycle.
REQ-021 States: RUN (redirectPending=0), HELD (redirectPending=1).
REQ-022 Edge, stall=0, redirect present: pcOut<=selected target; flush<=1; buffer cleared; state->RUN.
REQ-023 Edge, stall=0, no redirect, HELD: pcOut<=buffered target; flush<=1; state->RUN.
REQ-024 Edge, stall=0, no redirect, RUN: pcOut<=pcOut+4; flush<=0.
REQ-025 Edge, stall=1: pcOut SHALL hold; flush<=0.
REQ-026 Edge, stall=1, redirect present: buffer<=selected target, overwriting any previous buffered target; state->HELD.
REQ-027 Edge, stall=1, no redirect: buffer and state SHALL hold.
REQ-028 Live redirect at stall release SHALL win over buffered target (REQ-022).
REQ-029 Sequential increment SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-030 pcPlus4 SHALL follow pcOut combinationally with the same wrap.
REQ-031 Total latency redirect input -> pcOut SHALL be one edge when stall=0.
REQ-032 flush SHALL be high exactly one cycle per PC load from any redirect source.

Reset
REQ-033 Reset low SHALL immediately, without Clk, set pcOut=RESET_PC, flush=0, redirectPending=0, buffer=0.
REQ-034 Reset low mid-stall with HELD SHALL discard the buffered target.
REQ-035 First edge after Reset deasserts SHALL follow REQ-022..REQ-027 normally.

Verification
REQ-036 Reset, then 3 edges with no stall/redirect -> pcOut 0x0, 0x4, 0x8, 0xC; flush=0 throughout.
REQ-037 idPcPlus4=0xA000_0010, jumpEn=1, jumpTarget28=0x0000_400 -> next pcOut=0xA000_0400, flush=1 for one cycle, then pcOut=0xA000_0404, flush=0.
REQ-038 idPcPlus4=0x0000_0100, branchEn=1, branchImm=0xFFFE -> pcOut=0x0000_00F8; same cycle jrEn=1, jrTarget=0x0000_2003 -> pcOut=0x0000_2000.
REQ-039 stall=1 with jumpEn (target 0x0000_0040) for 1 cycle, stall held 2 more cycles -> pcOut frozen, redirectPending=1; on release with no redirect -> pcOut=0x40, flush=1, pending=0.
REQ-040 RESET_PC=0xFFFF_FFF8, two free-running edges -> pcOut 0xFFFF_FFFC, 0x0000_0000.
REQ-041 HELD state, assert Reset asynchronously between edges -> pcOut=RESET_PC, redirectPending=0 before next edge; buffered target never loaded.

Source files
------------

// File: rtl/next_pc_unit.sv
// Fetch PC register with jr/jump/branch redirect, one-deep redirect buffer and IF/ID flush.
// Latency: a redirect reaches pcOut on the next edge when stall is low; pcPlus4 is combinational.
// Backpressure: stall freezes pcOut; a redirect seen under stall is buffered and loaded on release.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic [31:0] idPcPlus4,
  input  logic        jumpEn,
  input  logic [27:0] jumpTarget28,
  input  logic        branchEn,
  input  logic [15:0] branchImm,
  input  logic        jrEn,
  input  logic [31:0] jrTarget,
  output logic [31:0] pcOut,
  output logic [31:0] pcPlus4,
  output logic        flush,
  output logic        redirectPending
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        flush_q, flush_d;

  logic        redirect;
  logic [31:0] jump_tgt;
  logic [31:0] branch_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] sel_tgt;
  logic [31:0] branch_off;

  // Candidate targets and priority select (jr over jump over branch).
  always_comb begin
    branch_off = {{14{branchImm[15]}}, branchImm, 2'b00};
    jump_tgt   = {idPcPlus4[31:28], jumpTarget28};
    branch_tgt = idPcPlus4 + branch_off;
    jr_tgt     = {jrTarget[31:2], 2'b00};
    redirect   = jrEn | jumpEn | branchEn;
    if (jrEn) begin
      sel_tgt = jr_tgt;
    end else if (jumpEn) begin
      sel_tgt = jump_tgt;
    end else begin
      sel_tgt = branch_tgt;
    end
  end

  // State register: RUN/HELD plus PC, buffered target and flush pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0000_0000;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      flush_q <= flush_d;
    end
  end

  // Next state: any unstalled edge returns to RUN; a redirect under stall parks in HELD.
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      state_d = ST_RUN;
    end else if (redirect) begin
      state_d = ST_HELD;
    end
  end

  // Datapath next values: live redirect beats the buffered one at stall release.
  always_comb begin
    pc_d    = pc_q;
    buf_d   = buf_q;
    flush_d = 1'b0;
    if (!stall) begin
      buf_d = 32'h0000_0000;
      if (redirect) begin
        pc_d    = sel_tgt;
        flush_d = 1'b1;
      end else if (state_q == ST_HELD) begin
        pc_d    = buf_q;
        flush_d = 1'b1;
      end else begin
        pc_d    = pc_q + 32'd4;
      end
    end else if (redirect) begin
      buf_d = sel_tgt;
    end
  end

  // Outputs: PC and flush straight from registers, pending decoded from state.
  always_comb begin
    pcOut           = pc_q;
    pcPlus4         = pc_q + 32'd4;
    flush           = flush_q;
    redirectPending = (state_q == ST_HELD);
  end

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

  logic        Clk;
  logic        Reset;
  logic        rst1_n;
  logic        stall;
  logic [31:0] idPcPlus4;
  logic        jumpEn;
  logic [27:0] jumpTarget28;
  logic        branchEn;
  logic [15:0] branchImm;
  logic        jrEn;
  logic [31:0] jrTarget;

  logic [31:0] pcOut, pcPlus4;
  logic        flush, redirectPending;
  logic [31:0] pcOut1, pcPlus4_1;
  logic        flush1, redirectPending1;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  next_pc_unit dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .idPcPlus4(idPcPlus4),
    .jumpEn(jumpEn), .jumpTarget28(jumpTarget28), .branchEn(branchEn),
    .branchImm(branchImm), .jrEn(jrEn), .jrTarget(jrTarget),
    .pcOut(pcOut), .pcPlus4(pcPlus4), .flush(flush), .redirectPending(redirectPending)
  );

  next_pc_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .Clk(Clk), .Reset(rst1_n), .stall(stall), .idPcPlus4(idPcPlus4),
    .jumpEn(jumpEn), .jumpTarget28(jumpTarget28), .branchEn(branchEn),
    .branchImm(branchImm), .jrEn(jrEn), .jrTarget(jrTarget),
    .pcOut(pcOut1), .pcPlus4(pcPlus4_1), .flush(flush1), .redirectPending(redirectPending1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: target arithmetic straight from the rules.
  function automatic logic [31:0] model_target(
    input logic jr, input logic jmp, input logic [31:0] id,
    input logic [27:0] jt, input logic [15:0] imm, input logic [31:0] jrt);
    int signed off;
    if (jr)  return jrt & 32'hFFFF_FFFC;
    if (jmp) return (id & 32'hF000_0000) | {4'h0, jt};
    off = int'($signed(imm)) * 4;
    return id + 32'(off);
  endfunction

  logic [31:0] m_pc, m_buf;
  logic        m_flush, m_pend;
  logic [31:0] m_tgt;
  logic        m_redir;
  assign m_tgt   = model_target(jrEn, jumpEn, idPcPlus4, jumpTarget28, branchImm, jrTarget);
  assign m_redir = jrEn || jumpEn || branchEn;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_pc <= 32'h0; m_buf <= 32'h0; m_flush <= 1'b0; m_pend <= 1'b0;
    end else if (stall) begin
      m_flush <= 1'b0;
      if (m_redir) begin
        m_buf  <= m_tgt;
        m_pend <= 1'b1;
      end
    end else begin
      m_pend  <= 1'b0;
      m_flush <= m_redir || m_pend;
      m_pc    <= m_redir ? m_tgt : (m_pend ? m_buf : m_pc + 32'd4);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("model_pcOut", pcOut, m_pc);
      chk("model_pcPlus4", pcPlus4, m_pc + 32'd4);
      chk("model_flush", {31'b0, flush}, {31'b0, m_flush});
      chk("model_pending", {31'b0, redirectPending}, {31'b0, m_pend});
    end
  end

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle();
    stall = 0; jumpEn = 0; branchEn = 0; jrEn = 0;
  endtask

  initial begin
    Reset = 0; rst1_n = 0;
    idle();
    idPcPlus4 = 0; jumpTarget28 = 0; branchImm = 0; jrTarget = 0;
    #3;
    chk("reset_pc", pcOut, 32'h0);
    chk("reset_flush", {31'b0, flush}, 32'h0);
    chk("reset_pending", {31'b0, redirectPending}, 32'h0);
    chk("reset_pcplus4", pcPlus4, 32'h4);
    step();
    Reset = 1;
    chk_en = 1;
    chk("seq0", pcOut, 32'h0);
    step(); chk("seq1", pcOut, 32'h4); chk("seq1_flush", {31'b0, flush}, 32'h0);
    step(); chk("seq2", pcOut, 32'h8); chk("seq2_flush", {31'b0, flush}, 32'h0);
    step(); chk("seq3", pcOut, 32'hC); chk("seq3_flush", {31'b0, flush}, 32'h0);

    // Jump keeps upper nibble of PC+4.
    idPcPlus4 = 32'hA000_0010; jumpEn = 1; jumpTarget28 = 28'h000_0400;
    step(); chk("jump_pc", pcOut, 32'hA000_0400); chk("jump_flush", {31'b0, flush}, 32'h1);
    idle();
    step(); chk("jump_next", pcOut, 32'hA000_0404); chk("jump_next_flush", {31'b0, flush}, 32'h0);

    // Negative branch offset, then jr beating branch.
    idPcPlus4 = 32'h0000_0100; branchEn = 1; branchImm = 16'hFFFE;
    step(); chk("branch_pc", pcOut, 32'h0000_00F8);
    jrEn = 1; jrTarget = 32'h0000_2003;
    step(); chk("jr_prio_pc", pcOut, 32'h0000_2000);
    jumpEn = 1; jumpTarget28 = 28'h000_0700;
    step(); chk("jr_over_jump", pcOut, 32'h0000_2000);
    jrEn = 0;
    step(); chk("jump_over_branch", pcOut, 32'h0000_0700);
    idle();
    step(); chk("after_redirect", pcOut, 32'h0000_0704);

    // Redirect buffered under stall, released with no live redirect.
    stall = 1; jumpEn = 1; idPcPlus4 = 32'h0000_2004; jumpTarget28 = 28'h000_0040;
    step(); chk("held_pc", pcOut, 32'h0000_0704); chk("held_pend", {31'b0, redirectPending}, 32'h1);
    jumpEn = 0;
    step(); chk("held_pc2", pcOut, 32'h0000_0704); chk("held_flush", {31'b0, flush}, 32'h0);
    step(); chk("held_pc3", pcOut, 32'h0000_0704); chk("held_pend3", {31'b0, redirectPending}, 32'h1);
    stall = 0;
    step(); chk("release_pc", pcOut, 32'h0000_0040); chk("release_flush", {31'b0, flush}, 32'h1);
    chk("release_pend", {31'b0, redirectPending}, 32'h0);
    step(); chk("release_next", pcOut, 32'h0000_0044); chk("release_next_flush", {31'b0, flush}, 32'h0);

    // Live redirect at release wins over the buffer.
    stall = 1; branchEn = 1; idPcPlus4 = 32'h0000_1000; branchImm = 16'h0010;
    step(); branchEn = 0;
    step(); stall = 0; jrEn = 1; jrTarget = 32'h0000_3000;
    step(); chk("live_wins", pcOut, 32'h0000_3000); chk("live_wins_flush", {31'b0, flush}, 32'h1);
    idle();
    step(); chk("live_wins_next", pcOut, 32'h0000_3004);

    // Wrap of the sequential increment.
    jrEn = 1; jrTarget = 32'hFFFF_FFFF;
    step(); chk("wrap_pc", pcOut, 32'hFFFF_FFFC); chk("wrap_plus4", pcPlus4, 32'h0);
    idle();
    step(); chk("wrap_next", pcOut, 32'h0); chk("wrap_flush", {31'b0, flush}, 32'h0);

    // Async reset while HELD discards the buffer.
    stall = 1; jumpEn = 1; idPcPlus4 = 32'h0; jumpTarget28 = 28'h000_0080;
    step(); chk("pre_rst_pend", {31'b0, redirectPending}, 32'h1);
    jumpEn = 0;
    #1 Reset = 0;
    #1;
    chk("async_rst_pc", pcOut, 32'h0);
    chk("async_rst_pend", {31'b0, redirectPending}, 32'h0);
    step();
    Reset = 1; stall = 0;
    step(); chk("post_rst_pc", pcOut, 32'h4); chk("post_rst_flush", {31'b0, flush}, 32'h0);

    // Non-default reset vector wraps through zero.
    rst1_n = 1;
    chk("rv_reset", pcOut1, 32'hFFFF_FFF8);
    step(); chk("rv_edge1", pcOut1, 32'hFFFF_FFFC);
    step(); chk("rv_edge2", pcOut1, 32'h0000_0000); chk("rv_plus4", pcPlus4_1, 32'h4);

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      stall        = ($urandom_range(0, 99) < 35);
      jrEn         = ($urandom_range(0, 99) < 12);
      jumpEn       = ($urandom_range(0, 99) < 15);
      branchEn     = ($urandom_range(0, 99) < 18);
      idPcPlus4    = $urandom;
      jumpTarget28 = 28'($urandom);
      branchImm    = 16'($urandom);
      jrTarget     = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        #1 Reset = 0;
        #1 chk("rand_async_rst", pcOut, 32'h0);
        step();
        Reset = 1;
      end else begin
        step();
      end
    end

    idle();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
